sram_ctrl: RTL and testbench

//   Digital access sequencer driving the SRAM macro (write_driver / cell_array / sense_amp).

---
 rtl/sram_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Access sequencer for the SRAM macro: accepts one read or write at a time and
// produces registered, timed write-data, wordline, precharge and sense strobes.
module sram_ctrl #(
    parameter int ROWS       = 2,
    parameter int COLS       = 8,
    parameter int PRE_CYCLES = 2,
    parameter int WR_CYCLES  = 10,
    parameter int RD_CYCLES  = 10,
    parameter int GAP_CYCLES = 2,
    localparam int ADDR_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [COLS-1:0]   wdata,
    output logic              ready,
    output logic              wdone,
    output logic              rvalid,
    output logic              err,
    output logic [COLS-1:0]   rdata,
    output logic [COLS-1:0]   data,
    output logic [ROWS-1:0]   row_wr,
    output logic [ROWS-1:0]   row_rd,
    output logic              pre_en,
    output logic              sa_en,
    input  logic [COLS-1:0]   sa_out
);

    localparam int MAX_PW = (PRE_CYCLES > WR_CYCLES) ? PRE_CYCLES : WR_CYCLES;
    localparam int MAX_RG = (RD_CYCLES > GAP_CYCLES) ? RD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_PW > MAX_RG) ? MAX_PW : MAX_RG;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, WR, PRE, RD, GAP, DONE, ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [COLS-1:0]     data_q, data_d;
    logic [COLS-1:0]     rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                wdone_q, wdone_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [ROWS-1:0]     row_wr_q, row_wr_d;
    logic [ROWS-1:0]     row_rd_q, row_rd_d;
    logic                pre_en_q, pre_en_d;
    logic                sa_en_q, sa_en_d;
    logic [ROWS-1:0]     row_sel;
    logic                addr_oob;

    assign addr_oob = ({1'b0, addr} >= (ADDR_W + 1)'(ROWS));

    // Wordline decode of the latched (next-cycle) address.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_sel[gi] = (addr_d == ADDR_W'(gi));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        data_d  = data_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = addr;
                    we_d   = we;
                    cnt_d  = '0;
                    if (addr_oob) begin
                        state_d = ERR;
                    end else if (we) begin
                        state_d = SETUP;
                        data_d  = wdata;
                    end else begin
                        state_d = PRE;
                    end
                end
            end
            SETUP: begin
                state_d = WR;
                cnt_d   = '0;
            end
            WR: begin
                if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRE: begin
                if (cnt_q == CNT_W'(PRE_CYCLES - 1)) begin
                    state_d = RD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD: begin
                if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
                    // Last cycle of the read pulse: sa_en is high now, capture the result.
                    state_d = GAP;
                    cnt_d   = '0;
                    rdata_d = sa_out;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ready_d  = (state_d == IDLE);
        wdone_d  = (state_d == DONE) && we_d;
        rvalid_d = (state_d == DONE) && !we_d;
        err_d    = (state_d == ERR);
        row_wr_d = (state_d == WR) ? row_sel : '0;
        row_rd_d = (state_d == RD) ? row_sel : '0;
        pre_en_d = (state_d == PRE);
        sa_en_d  = (state_d == RD) && (cnt_d == CNT_W'(RD_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b1;
            wdone_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            row_wr_q <= '0;
            row_rd_q <= '0;
            pre_en_q <= 1'b0;
            sa_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            wdone_q  <= wdone_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            row_wr_q <= row_wr_d;
            row_rd_q <= row_rd_d;
            pre_en_q <= pre_en_d;
            sa_en_q  <= sa_en_d;
        end
    end

    assign ready  = ready_q;
    assign wdone  = wdone_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign data   = data_q;
    assign row_wr = row_wr_q;
    assign row_rd = row_rd_q;
    assign pre_en = pre_en_q;
    assign sa_en  = sa_en_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: a 2-row and a 3-row instance are checked cycle by
// cycle against a timing model derived from the cycle-number formulas of each access.
module tb_sram_ctrl;

    localparam int P = 2;
    localparam int W = 10;
    localparam int R = 10;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       req = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] sa_out = '0;

    logic       req2, req3;
    logic       ready2, wdone2, rvalid2, err2, pre_en2, sa_en2;
    logic [7:0] rdata2, data2;
    logic [1:0] row_wr2, row_rd2;
    logic       ready3, wdone3, rvalid3, err3, pre_en3, sa_en3;
    logic [7:0] rdata3, data3;
    logic [2:0] row_wr3, row_rd3;

    always #5 clk = ~clk;

    assign req2 = req & ~sel;
    assign req3 = req & sel;

    sram_ctrl u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr[0:0]), .wdata(wdata),
        .ready(ready2), .wdone(wdone2), .rvalid(rvalid2), .err(err2), .rdata(rdata2),
        .data(data2), .row_wr(row_wr2), .row_rd(row_rd2), .pre_en(pre_en2),
        .sa_en(sa_en2), .sa_out(sa_out)
    );

    sram_ctrl #(.ROWS(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready3), .wdone(wdone3), .rvalid(rvalid3), .err(err3), .rdata(rdata3),
        .data(data3), .row_wr(row_wr3), .row_rd(row_rd3), .pre_en(pre_en3),
        .sa_en(sa_en3), .sa_out(sa_out)
    );

    logic       o_ready, o_pre, o_sa;
    logic [2:0] o_wr, o_rd, o_pulse;
    logic [7:0] o_data, o_rdata;

    assign o_ready = sel ? ready3 : ready2;
    assign o_pre   = sel ? pre_en3 : pre_en2;
    assign o_sa    = sel ? sa_en3 : sa_en2;
    assign o_wr    = sel ? row_wr3 : {1'b0, row_wr2};
    assign o_rd    = sel ? row_rd3 : {1'b0, row_rd2};
    assign o_pulse = sel ? {wdone3, rvalid3, err3} : {wdone2, rvalid2, err2};
    assign o_data  = sel ? data3 : data2;
    assign o_rdata = sel ? rdata3 : rdata2;

    // Reference state: array contents, write-driver data and last read result per instance.
    logic [7:0] mem [2][3];
    logic [7:0] data_m [2];
    logic [7:0] rdata_m [2];

    int         n_vec = 0;
    int         n_bad = 0;
    logic       next_we;
    int         next_addr;
    logic [7:0] next_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t, rows=%0d)", tag, obs, exp, $time,
                     sel ? 3 : 2);
        end
    endtask

    task automatic check_idle();
        int s;
        s = int'(sel);
        check("idle_ready", 32'(o_ready), 32'd1);
        check("idle_strobes", {26'd0, o_wr, o_rd}, 32'd0);
        check("idle_pre_sa", {30'd0, o_pre, o_sa}, 32'd0);
        check("idle_pulses", 32'(o_pulse), 32'd0);
        check("idle_data", 32'(o_data), 32'(data_m[s]));
        check("idle_rdata", 32'(o_rdata), 32'(rdata_m[s]));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req    = 1'b0;
        check_idle();
        sa_out = 8'($urandom);
    endtask

    // One access: n counts cycles after the accept edge, expectations follow the access timing.
    task automatic issue(input logic w, input int a, input logic [7:0] wd,
                         input logic keep, input int abort_at);
        int         s, d;
        logic       oob, viol;
        logic [2:0] oh, e_wr, e_rd, e_pulse;
        logic       e_pre, e_sa;
        s = int'(sel);
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = a[1:0];
        wdata = wd;
        check("ready_at_accept", 32'(o_ready), 32'd1);
        sa_out = 8'($urandom);
        oob = (a >= (sel ? 3 : 2));
        oh  = 3'(1 << a);
        d   = oob ? 1 : (w ? 2 + W + G : P + R + G + 1);
        for (int n = 1; n <= d; n++) begin
            @(negedge clk);
            if (n == 1) begin
                if (keep) begin
                    we    = next_we;
                    addr  = next_addr[1:0];
                    wdata = next_wdata;
                end else begin
                    req = 1'b0;
                end
            end
            if (!oob && w && n == 1) data_m[s] = wd;
            if (!oob && !w && n == P + R + 1) rdata_m[s] = mem[s][a];
            e_wr    = (!oob && w && n >= 2 && n <= 1 + W) ? oh : 3'd0;
            e_rd    = (!oob && !w && n >= P + 1 && n <= P + R) ? oh : 3'd0;
            e_pre   = !oob && !w && n <= P;
            e_sa    = !oob && !w && n == P + R;
            e_pulse = {!oob && w && n == d, !oob && !w && n == d, oob && n == 1};
            check("busy_ready", 32'(o_ready), 32'd0);
            check("row_wr", 32'(o_wr), 32'(e_wr));
            check("row_rd", 32'(o_rd), 32'(e_rd));
            check("pre_en/sa_en", {30'd0, o_pre, o_sa}, {30'd0, e_pre, e_sa});
            check("wdone/rvalid/err", 32'(o_pulse), 32'(e_pulse));
            check("data", 32'(o_data), 32'(data_m[s]));
            check("rdata", 32'(o_rdata), 32'(rdata_m[s]));
            viol = ((|o_wr) && (|o_rd)) || !$onehot0(o_wr) || !$onehot0(o_rd) ||
                   (o_pre && ((|o_wr) || (|o_rd))) || (o_sa && !(|o_rd));
            check("invariants", 32'(viol), 32'd0);
            // Only the sense cycle carries the real cell value; anything else is noise.
            sa_out = e_sa ? mem[s][a] : 8'($urandom);
            if (n == abort_at) begin
                rst = 1'b1;
                req = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    data_m[k]  = 8'h00;
                    rdata_m[k] = 8'h00;
                end
                check_idle();
                return;
            end
        end
        if (!oob && w) mem[s][a] = wd;
    endtask

    task automatic random_ops(input int count, input int amax);
        logic       cw, keep;
        int         ca;
        logic [7:0] cd;
        cw = 1'($urandom);
        ca = $urandom_range(amax);
        cd = 8'($urandom);
        for (int i = 0; i < count; i++) begin
            next_we    = 1'($urandom);
            next_addr  = $urandom_range(amax);
            next_wdata = 8'($urandom);
            keep       = ($urandom_range(3) == 0);
            issue(cw, ca, cd, keep, 0);
            if (!keep) begin
                repeat ($urandom_range(2)) idle_cycle();
            end
            cw = next_we;
            ca = next_addr;
            cd = next_wdata;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            data_m[k]  = 8'h00;
            rdata_m[k] = 8'h00;
            for (int j = 0; j < 3; j++) mem[k][j] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle();
        sel = 1'b1;
        #1;
        check_idle();
        sel = 1'b0;
        rst = 1'b0;

        // Write row0, then read it back.
        issue(1'b1, 0, 8'b10110111, 1'b0, 0);
        issue(1'b0, 0, 8'h00, 1'b0, 0);

        // Held request: write row1, read row1 accepted on the first ready edge.
        next_we    = 1'b0;
        next_addr  = 1;
        next_wdata = 8'hC3;
        issue(1'b1, 1, 8'h5A, 1'b1, 0);
        issue(1'b0, 1, 8'hC3, 1'b0, 0);
        idle_cycle();

        // Three-row instance: out-of-range address, then a real access to the top row.
        sel = 1'b1;
        issue(1'b1, 3, 8'hFF, 1'b0, 0);
        idle_cycle();
        issue(1'b0, 3, 8'h00, 1'b0, 0);
        idle_cycle();
        issue(1'b1, 2, 8'h96, 1'b0, 0);
        issue(1'b0, 2, 8'h00, 1'b0, 0);
        random_ops(100, 3);
        idle_cycle();

        // Reset in write cycle 5 abandons the access.
        sel = 1'b0;
        issue(1'b1, 0, 8'h33, 1'b0, 5);
        repeat (W + G + 2) idle_cycle();
        issue(1'b0, 0, 8'h00, 1'b0, 0);

        random_ops(1000, 1);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
